// File: rtl/numarator_pkg.sv
// Shared types and constants for the mm:ss countdown timer (numarator_descrescator).
package numarator_pkg;

    localparam int VAL_W   = 6;
    localparam int SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate an operator-entered digit pair to the largest legal value.
    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v,
                                                  input logic [VAL_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/cifra_desc.sv
// One mod-(MAX+1) down-counting digit field with load, enable and a borrow
// that fires while the field is at zero and enabled (i.e. on the wrap to MAX).
module cifra_desc
    import numarator_pkg::*;
#(
    parameter int MAX = SEC_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [VAL_W-1:0] ld_val,
    output logic [VAL_W-1:0] value,
    output logic             borrow
);

    localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX);
    localparam logic [VAL_W-1:0] ONE_V = VAL_W'(1);

    assign borrow = en && (value == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (ld) begin
            value <= ld_val;
        end else if (en) begin
            value <= (value == '0) ? MAX_V : value - ONE_V;
        end
    end

endmodule

// File: rtl/numarator_descrescator.sv
// mm:ss countdown timer with load/start/pause control.
// Optional NUMARATOR_AUTO_RELOAD_EN: restart from the stored value instead of stopping at 00:00.
module numarator_descrescator
    import numarator_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic             clk_out_led,
    input  logic             reset,
    input  logic             load,
    input  logic [VAL_W-1:0] min_in,
    input  logic [VAL_W-1:0] sec_in,
    input  logic             start,
    input  logic             pauza,
    output logic [VAL_W-1:0] valoarea_min,
    output logic [VAL_W-1:0] valoarea_sec,
    output logic             borrow_out,
    output logic             gata,
    output logic             activ
);

`ifdef NUMARATOR_AUTO_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [VAL_W-1:0] MIN_LIM = VAL_W'(MAX_MIN);
    localparam logic [VAL_W-1:0] SEC_LIM = VAL_W'(SEC_MAX);

    state_t           state;
    state_t           state_next;
    logic [VAL_W-1:0] stored_min;
    logic [VAL_W-1:0] stored_sec;
    logic [VAL_W-1:0] load_min;
    logic [VAL_W-1:0] load_sec;
    logic [VAL_W-1:0] cnt_ld_min;
    logic [VAL_W-1:0] cnt_ld_sec;
    logic             cnt_ld;
    logic             dec_en;
    logic             sec_borrow;
    logic             unused_min_borrow;
    logic             count_zero;
    logic             count_one;
    logic             stored_nonzero;

    assign load_min       = clamp_val(min_in, MIN_LIM);
    assign load_sec       = clamp_val(sec_in, SEC_LIM);
    assign count_zero     = (valoarea_min == '0) && (valoarea_sec == '0);
    assign count_one      = (valoarea_min == '0) && (valoarea_sec == VAL_W'(1));
    assign stored_nonzero = (stored_min != '0) || (stored_sec != '0);

    // The minutes field only steps when the seconds field wraps; it never
    // underflows because the count is never decremented from 00:00.
    cifra_desc #(.MAX(SEC_MAX)) u_sec (
        .clk    (clk_out_led),
        .reset  (reset),
        .en     (dec_en),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_sec),
        .value  (valoarea_sec),
        .borrow (sec_borrow)
    );

    cifra_desc #(.MAX(MAX_MIN)) u_min (
        .clk    (clk_out_led),
        .reset  (reset),
        .en     (sec_borrow),
        .ld     (cnt_ld),
        .ld_val (cnt_ld_min),
        .value  (valoarea_min),
        .borrow (unused_min_borrow)
    );

    always_comb begin
        state_next = state;
        dec_en     = 1'b0;
        cnt_ld     = 1'b0;
        cnt_ld_min = load_min;
        cnt_ld_sec = load_sec;
        case (state)
            RUN: begin
                if (pauza) begin
                    state_next = PAUSE;
                end else if (count_zero) begin
                    // Only reachable with auto-reload: the cycle after 00:00 restarts the run.
                    if (AUTO_RELOAD) begin
                        cnt_ld     = 1'b1;
                        cnt_ld_min = stored_min;
                        cnt_ld_sec = stored_sec;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    dec_en = 1'b1;
                    if (count_one && !AUTO_RELOAD) begin
                        state_next = DONE;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    cnt_ld     = 1'b1;
                    state_next = IDLE;
                end else if (!pauza) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    cnt_ld     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                if (load) begin
                    cnt_ld     = 1'b1;
                    state_next = IDLE;
                end else if (!pauza && start && stored_nonzero) begin
                    state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk_out_led) begin
        if (reset) begin
            state      <= IDLE;
            stored_min <= '0;
            stored_sec <= '0;
            borrow_out <= 1'b0;
            gata       <= 1'b0;
            activ      <= 1'b0;
        end else begin
            state      <= state_next;
            activ      <= (state_next == RUN) || (state_next == PAUSE);
            borrow_out <= sec_borrow;
            gata       <= dec_en && count_one;
            if (load && (state != RUN)) begin
                stored_min <= load_min;
                stored_sec <= load_sec;
            end
        end
    end

endmodule

// File: tb/tb_numarator_descrescator.sv
// Self-checking bench for numarator_descrescator: directed scenarios then random
// control traffic, compared against a remaining-seconds reference model.
module tb_numarator_descrescator;

    localparam int MAX_MIN = 59;
`ifdef NUMARATOR_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk_out_led = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pauza = 1'b0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [5:0] valoarea_min;
    logic [5:0] valoarea_sec;
    logic       borrow_out;
    logic       gata;
    logic       activ;

    always #5 clk_out_led = ~clk_out_led;

    numarator_descrescator #(.MAX_MIN(MAX_MIN)) dut (
        .clk_out_led  (clk_out_led),
        .reset        (reset),
        .load         (load),
        .min_in       (min_in),
        .sec_in       (sec_in),
        .start        (start),
        .pauza        (pauza),
        .valoarea_min (valoarea_min),
        .valoarea_sec (valoarea_sec),
        .borrow_out   (borrow_out),
        .gata         (gata),
        .activ        (activ)
    );

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    rem = 0;
    int    stored_total = 0;
    mode_t mode = M_IDLE;
    bit    exp_borrow = 1'b0;
    bit    exp_gata = 1'b0;

    // Model works on total remaining seconds; mm:ss is derived by division.
    task automatic modelStep();
        int m;
        int s;
        exp_borrow = 1'b0;
        exp_gata   = 1'b0;
        if (reset) begin
            mode = M_IDLE;
            rem = 0;
            stored_total = 0;
        end else if (load && mode != M_RUN) begin
            m = (int'(min_in) > MAX_MIN) ? MAX_MIN : int'(min_in);
            s = (int'(sec_in) > 59) ? 59 : int'(sec_in);
            stored_total = m * 60 + s;
            rem = stored_total;
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE:  if (!pauza && start && stored_total != 0) mode = M_RUN;
                M_PAUSE: if (!pauza) mode = M_RUN;
                M_RUN: begin
                    if (pauza) begin
                        mode = M_PAUSE;
                    end else if (rem == 0) begin
                        rem = stored_total;
                    end else begin
                        if (rem % 60 == 0) exp_borrow = 1'b1;
                        rem = rem - 1;
                        if (rem == 0) begin
                            exp_gata = 1'b1;
                            if (!AUTO) mode = M_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        bit exp_activ;
        exp_activ = (mode == M_RUN) || (mode == M_PAUSE);
        n_checks++;
        assert (valoarea_min === 6'(rem / 60)) else begin
            n_fails++;
            $error("FAIL %s min: observed=%0d expected=%0d", tag, valoarea_min, rem / 60);
        end
        n_checks++;
        assert (valoarea_sec === 6'(rem % 60)) else begin
            n_fails++;
            $error("FAIL %s sec: observed=%0d expected=%0d", tag, valoarea_sec, rem % 60);
        end
        n_checks++;
        assert (borrow_out === exp_borrow) else begin
            n_fails++;
            $error("FAIL %s borrow_out: observed=%b expected=%b", tag, borrow_out, exp_borrow);
        end
        n_checks++;
        assert (gata === exp_gata) else begin
            n_fails++;
            $error("FAIL %s gata: observed=%b expected=%b", tag, gata, exp_gata);
        end
        n_checks++;
        assert (activ === exp_activ) else begin
            n_fails++;
            $error("FAIL %s activ: observed=%b expected=%b", tag, activ, exp_activ);
        end
    endtask

    task automatic applyStimulus(input string tag, input bit rs, input bit ld,
                                 input bit st, input bit pz,
                                 input logic [5:0] mi, input logic [5:0] si);
        reset  = rs;
        load   = ld;
        start  = st;
        pauza  = pz;
        min_in = mi;
        sec_in = si;
        @(posedge clk_out_led);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 6'd0, 6'd0);
    endtask

    initial begin
        bit         rs;
        bit         ld;
        bit         st;
        bit         pz;
        logic [5:0] mi;
        logic [5:0] si;

        applyStimulus("reset", 1, 0, 0, 0, 6'd0, 6'd0);
        applyStimulus("reset", 1, 1, 1, 0, 6'd5, 6'd5);
        idleCycles("reset_idle", 1);

        // Short countdown to 00:00, then DONE ignores start.
        applyStimulus("load_0003", 0, 1, 0, 0, 6'd0, 6'd3);
        applyStimulus("start_0003", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("count_0003", 3);
        applyStimulus("done_start", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("done_hold", 2);

        // Seconds wrap with borrow.
        applyStimulus("load_0200", 0, 1, 0, 0, 6'd2, 6'd0);
        applyStimulus("start_0200", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("borrow_0200", 3);
        applyStimulus("load_in_run", 0, 1, 0, 0, 6'd5, 6'd5);

        // Pause and release.
        applyStimulus("pause_load", 0, 0, 0, 1, 6'd0, 6'd0);
        applyStimulus("load_0010", 0, 1, 0, 0, 6'd0, 6'd10);
        applyStimulus("start_0010", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("run_0010", 3);
        for (int i = 0; i < 4; i++) applyStimulus("paused", 0, 0, 1, 1, 6'd0, 6'd0);
        applyStimulus("release", 0, 0, 0, 0, 6'd0, 6'd0);
        idleCycles("after_release", 1);

        // Clamping of out-of-range load values.
        applyStimulus("pause_again", 0, 0, 0, 1, 6'd0, 6'd0);
        applyStimulus("load_clamp", 0, 1, 0, 0, 6'd63, 6'd61);
        n_checks++;
        assert (valoarea_min === 6'd59 && valoarea_sec === 6'd59) else begin
            n_fails++;
            $error("FAIL clamp_const: observed=%0d:%0d expected=59:59", valoarea_min, valoarea_sec);
        end
        applyStimulus("start_clamp", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("run_clamp", 2);

        // Reset mid-countdown; stored value is cleared so start is ignored.
        applyStimulus("reset_mid", 1, 0, 0, 0, 6'd0, 6'd0);
        applyStimulus("load_0008", 0, 1, 0, 0, 6'd0, 6'd8);
        applyStimulus("start_0008", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("run_0008", 3);
        applyStimulus("reset_run", 1, 1, 1, 1, 6'd9, 6'd9);
        applyStimulus("start_after_reset", 0, 0, 1, 0, 6'd0, 6'd0);
        idleCycles("idle_after_reset", 2);

        if (AUTO) begin
            applyStimulus("load_0002", 0, 1, 0, 0, 6'd0, 6'd2);
            applyStimulus("start_0002", 0, 0, 1, 0, 6'd0, 6'd0);
            idleCycles("auto_reload", 6);
        end

        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(99) == 0);
            ld = ($urandom_range(19) == 0);
            st = ($urandom_range(3) == 0);
            pz = ($urandom_range(7) == 0);
            mi = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'($urandom_range(1));
            si = 6'($urandom_range(63));
            applyStimulus("random", rs, ld, st, pz, mi, si);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
